// File: rtl/qu_pkg.sv
// Shared types for the instruction fetch stage: PC/instruction words, queue entry, FSM state.
package qu_pkg;
    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;

    typedef logic [PC_W-1:0]    pc_t;
    typedef logic [INSTR_W-1:0] instr_t;

    typedef struct packed {
        instr_t data;
        pc_t    pc;
    } fetch_entry_t;

    typedef enum logic {BOOT, RUN} fetch_state_t;
endpackage

// File: rtl/fetch_queue.sv
// In-order circular FIFO of fetch entries; clear empties it in one cycle.
module fetch_queue
    import qu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  fetch_entry_t             wr_entry,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
        end
    end

    // Storage needs no reset: count gates visibility of every slot.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: issues imem reads from pc_in, queues {instr, pc} for decode, flushes on redirect.
// Optional FETCH_PERF_CTR_EN adds fetched/flushed/stall performance counters.
module fetch_unit
    import qu_pkg::*;
#(
    parameter int PC_WIDTH    = PC_W,
    parameter int INSTR_WIDTH = INSTR_W,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PC_WIDTH-1:0]    pc_in,
    output logic                   pc_en,
    input  logic                   flush,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr_data,
    output logic [PC_WIDTH-1:0]    instr_pc
`ifdef FETCH_PERF_CTR_EN
    ,
    output logic [31:0]            perf_fetched,
    output logic [31:0]            perf_flushed,
    output logic [31:0]            perf_stall
`endif
);
    fetch_state_t                   state;
    logic                           inflight_vld;
    pc_t                            inflight_pc;
    logic [$clog2(QUEUE_DEPTH):0]   count;
    logic                           q_empty;
    logic                           q_full;
    logic                           issue;
    logic                           push;
    logic                           pop;
    fetch_entry_t                   head;
    fetch_entry_t                   wr_entry;

    // The in-flight read holds a credit so the queue can never overflow.
    assign issue = (state == RUN) && !flush &&
                   ((int'(count) + int'(inflight_vld)) < QUEUE_DEPTH);
    assign push  = inflight_vld && !flush;
    assign pop   = !q_empty && instr_ready && !flush;

    assign wr_entry.data = imem_rdata;
    assign wr_entry.pc   = inflight_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= BOOT;
            inflight_vld <= 1'b0;
            inflight_pc  <= '0;
        end else begin
            state        <= RUN;
            inflight_vld <= issue;
            if (issue) inflight_pc <= pc_in;
        end
    end

    fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .clear    (flush),
        .wr_entry (wr_entry),
        .head     (head),
        .count    (count),
        .empty    (q_empty),
        .full     (q_full)
    );

    // pc_en during flush lets pc_ctr load its redirect target.
    assign imem_req    = !rst && issue;
    assign pc_en       = !rst && (issue || flush);
    assign imem_addr   = rst ? '0 : pc_in;
    assign instr_valid = !rst && !q_empty;
    assign instr_data  = rst ? '0 : head.data;
    assign instr_pc    = rst ? '0 : head.pc;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && q_full && !pop));

`ifdef FETCH_PERF_CTR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
            perf_stall   <= '0;
        end else begin
            if (push) perf_fetched <= perf_fetched + 32'd1;
            if (flush) perf_flushed <= perf_flushed + 32'(count) + 32'(inflight_vld);
            if (state == RUN && !issue && !flush) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit with a queue-level model and a redirect-aware PC stream check.
module tb_fetch_unit;
    logic        clk;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_en;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
`ifdef FETCH_PERF_CTR_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
    logic [31:0] perf_stall;
`endif

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .pc_in       (pc_in),
        .pc_en       (pc_en),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .instr_pc    (instr_pc)
`ifdef FETCH_PERF_CTR_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_flushed(perf_flushed),
        .perf_stall  (perf_stall)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] target;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Environment: pc_ctr and a one-cycle-latency instruction memory.
    always @(posedge clk) begin
        if (rst)        pc_in <= '0;
        else if (flush) pc_in <= target;
        else if (pc_en) pc_in <= pc_in + 32'd1;
    end
    always @(posedge clk)
        imem_rdata <= imem_req ? (32'hA000_0000 + imem_addr) : 32'hDEAD_BEEF;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Model state: queued PCs, the outstanding read, and whether BOOT has passed.
    logic [31:0] mq[$];
    bit          inf_v;
    logic [31:0] inf_pc;
    bit          booted;
    logic [31:0] exp_next;
    logic [31:0] acc_q[$];
    int          m_fetched, m_flushed, m_stall;

    initial begin
        inf_v = 0; inf_pc = 0; booted = 0; exp_next = 0;
        m_fetched = 0; m_flushed = 0; m_stall = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_req", {31'd0, imem_req}, 32'd0);
                chk("rst_en", {31'd0, pc_en}, 32'd0);
                chk("rst_valid", {31'd0, instr_valid}, 32'd0);
                chk("rst_data", instr_data, 32'd0);
                chk("rst_pc", instr_pc, 32'd0);
                chk("rst_addr", imem_addr, 32'd0);
                mq.delete(); inf_v = 0; booted = 0; exp_next = 0; acc_q.delete();
                m_fetched = 0; m_flushed = 0; m_stall = 0;
            end else begin
                bit exp_req;
                bit exp_valid;
                exp_valid = (mq.size() != 0);
                exp_req   = booted && !flush && (mq.size() + int'(inf_v) < 4);
                chk("req", {31'd0, imem_req}, {31'd0, exp_req});
                chk("pc_en", {31'd0, pc_en}, {31'd0, exp_req | flush});
                chk("addr", imem_addr, pc_in);
                chk("valid", {31'd0, instr_valid}, {31'd0, exp_valid});
                if (exp_valid) begin
                    chk("head_pc", instr_pc, mq[0]);
                    chk("head_data", instr_data, 32'hA000_0000 + mq[0]);
                end
`ifdef FETCH_PERF_CTR_EN
                chk("perf_fetched", perf_fetched, m_fetched);
                chk("perf_flushed", perf_flushed, m_flushed);
                chk("perf_stall", perf_stall, m_stall);
`endif
                // Decode must see the PC stream in order from the last redirect.
                if (instr_valid && instr_ready && !flush) begin
                    chk("stream_pc", instr_pc, exp_next);
                    acc_q.push_back(instr_pc);
                    exp_next = instr_pc + 32'd1;
                end
                if (booted && !flush && !exp_req) m_stall++;
                if (flush) begin
                    m_flushed += mq.size() + int'(inf_v);
                    mq.delete(); inf_v = 0;
                    exp_next = target;
                end else begin
                    if (exp_valid && instr_ready) void'(mq.pop_front());
                    if (inf_v) begin mq.push_back(inf_pc); m_fetched++; end
                    inf_v = exp_req;
                    inf_pc = pc_in;
                end
                booted = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input int n);
        rst = 1; flush = 0;
        steps(n);
        rst = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int first;
        int n;
        rst = 1; flush = 0; instr_ready = 1; target = 0;
        steps(3);

        // Free run: first valid 3 cycles after reset release.
        rst = 0;
        first = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            if (instr_valid && first < 0) first = k;
        end
        chk("first_valid_cycle", first, 3);
        step();
        steps(15);

        // Back-pressure from reset: exactly PC 0..3 buffered, PC held.
        do_reset(2);
        instr_ready = 0;
        steps(10);
        @(negedge clk); #1;
        chk("stall_head_pc", instr_pc, 32'd0);
        chk("stall_req", {31'd0, imem_req}, 32'd0);
        chk("stall_en", {31'd0, pc_en}, 32'd0);
        chk("stall_depth", mq.size(), 4);
        step();
        instr_ready = 1;
        steps(8);
        chk("stall_resume0", acc_q.size() > 4 ? acc_q[0] : 32'hFFFF_FFFF, 32'd0);
        chk("stall_resume4", acc_q.size() > 4 ? acc_q[4] : 32'hFFFF_FFFF, 32'd4);

        // Redirect to 15 mid-stream.
        flush = 1; target = 15; acc_q.delete();
        step();
        flush = 0;
        @(negedge clk); #1;
        chk("flush_empty", {31'd0, instr_valid}, 32'd0);
        step();
        steps(6);
        chk("redir_pc0", acc_q.size() > 1 ? acc_q[0] : 32'hFFFF_FFFF, 32'd15);
        chk("redir_pc1", acc_q.size() > 1 ? acc_q[1] : 32'hFFFF_FFFF, 32'd16);

        // Flush on a full queue with pop requested in the same cycle.
        instr_ready = 0;
        steps(8);
        chk("full_before_flush", mq.size(), 4);
        flush = 1; instr_ready = 1; target = 40; acc_q.delete();
        step();
        flush = 0;
        @(negedge clk); #1;
        chk("full_flush_empty", {31'd0, instr_valid}, 32'd0);
        chk("full_flush_noacc", acc_q.size(), 0);
        step();
        steps(6);
        chk("full_flush_next", acc_q.size() > 0 ? acc_q[0] : 32'hFFFF_FFFF, 32'd40);

        // Random ready/flush traffic.
        for (int i = 0; i < 400; i++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 19) == 0);
            target = $urandom_range(0, 1000);
            step();
        end
        flush = 0; instr_ready = 1;
        steps(4);

        // Reset with 3 entries queued.
        instr_ready = 0;
        n = 0;
        while (mq.size() != 3 && n < 20) begin step(); n++; end
        chk("fill3_bound", {31'd0, n < 20}, 32'd1);
        rst = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
            chk("midrst_req", {31'd0, imem_req}, 32'd0);
            step();
        end
        rst = 0; instr_ready = 1;
        steps(10);
        chk("post_rst_pc0", acc_q.size() > 0 ? acc_q[0] : 32'hFFFF_FFFF, 32'd0);

`ifdef FETCH_PERF_CTR_EN
        // Flush with 3 queued entries and one outstanding read.
        do_reset(2);
        instr_ready = 0;
        n = 0;
        while (!(mq.size() == 3 && inf_v) && n < 20) begin step(); n++; end
        chk("perf_fill_bound", {31'd0, n < 20}, 32'd1);
        flush = 1; target = 100; instr_ready = 1;
        step();
        flush = 0;
        steps(20);
        @(negedge clk); #1;
        chk("perf_flushed_lit", perf_flushed, 32'd4);
        chk("perf_fetched_obs", perf_fetched, m_fetched);
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
